tx_source_arbiter: RTL and testbench
====================================

// Module: tx_source_arbiter
// PURPOSE
//  Shares the single tx serializer byte interface (d_in / d_in_valid / read_enable) among
//  NUM_REQ byte-stream sources, e.g. host tx_fifo, loopback and test-pattern generator.
//  Grants are packet-granular and round-robin, limited to MAX_BURST bytes, with GAP_CYCLES
//  of forced idle between grants. Sits between the source FIFOs and tx in the clk_bit domain.
// PARAMETERS
//  NUM_REQ     2   number of requesters, 2..8
//  MAX_BURST   64  max bytes per grant before a forced hand-over, 1..255
//  GAP_CYCLES  4   clk_bit cycles of idle after each grant ends, 0..255
// PORTS
//  clk_bit         in   1          bit clock; the only clock
//  rst_n           in   1          asynchronous, active-low reset
//  req_enable      in   NUM_REQ    per-requester config enable
//  req_valid       in   NUM_REQ    requester i has a byte at its head (i.e. FIFO not empty)
//  req_data        in   8*NUM_REQ  head byte of requester i, in bits [8i+7:8i]
//  req_last        in   NUM_REQ    head byte of requester i ends a packet
//  req_read        out  NUM_REQ    pop strobe to requester i; at most one bit set
//  tx_d_in         out  8          byte to tx
//  tx_d_valid      out  1          drives tx d_in_valid
//  tx_read_enable  in   1          tx pops tx_d_in this cycle
//  grant           out  NUM_REQ    one-hot current owner; zero when not in GRANT
//  burst_trunc     out  1          one-cycle pulse: grant ended at MAX_BURST without last
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, grant=0, req_read=0, tx_d_valid=0, tx_d_in=0,
//   burst_trunc=0, burst count=0, gap count=0, round-robin pointer=0 (req 0 has top priority).
//  Eligible(i) = req_enable[i] & req_valid[i].
//  FSM states:
//   IDLE  : no eligible requester. Go to ARB the cycle after any requester is eligible.
//   ARB   : one cycle. Pick the first eligible i, scanning from the pointer upward with wrap.
//           Register owner=i, set pointer=(i+1) mod NUM_REQ, clear burst count, go to GRANT.
//           If nothing is eligible (it dropped), return to IDLE.
//   GRANT : grant=onehot(owner). Datapath is combinational with zero latency:
//           tx_d_in=req_data[owner], tx_d_valid=req_valid[owner],
//           req_read[owner]=tx_read_enable & tx_d_valid.
//           Each pop increments the burst count. On a pop with req_last[owner]: go to GAP.
//           On a pop that makes count==MAX_BURST without last: go to GAP and pulse
//           burst_trunc. req_valid[owner] low mid-packet: tx_d_valid low; stay in GRANT
//           (no timeout). req_enable[owner] dropping mid-packet: ignored until the packet or
//           burst ends. Enable is sampled only in ARB.
//   GAP   : grant=0, tx_d_valid=0. Load GAP_CYCLES and count down, then go to ARB.
//           If GAP_CYCLES=0, go straight from GRANT to ARB, with one ARB cycle as the only gap.
//  tx_read_enable with tx_d_valid low is ignored: no pop, no count. tx_d_in outside GRANT is
//   8'h00.
//  Counters: burst count is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST. Gap count
//   is 8 bits. Neither counter wraps.
//  Pop and last on the same byte as count reaching MAX_BURST: treat as a normal end, with no
//   burst_trunc.
//  Reset mid-GRANT: the outputs clear immediately and asynchronously. Bytes already popped
//   stay popped; the partial packet is the downstream framer's concern.
// TESTING
//  1. Only req0 is eligible with a 3-byte packet {A1,A2,A3(last)}, tx pops every cycle ->
//     tx_d_in shows A1,A2,A3 on 3 consecutive GRANT cycles; req_read=01 on each; then 4 GAP
//     cycles with grant=00.
//  2. req0 and req1 are both eligible with endless 2-byte packets -> grants alternate
//     req0,req1,req0,...; no requester gets two consecutive grants.
//  3. req1 streams 70 bytes with no last, MAX_BURST=64 -> exactly 64 pops, then burst_trunc
//     pulses once; the remaining 6 bytes go in the next req1 grant.
//  4. Owner req_valid drops for 5 cycles mid-packet, while tx_read_enable stays high ->
//     tx_d_valid=0 and req_read=0 for those 5 cycles; grant is held; the packet resumes intact.
//  5. req_enable[0] drops mid-packet -> the packet completes; req0 is not granted again until
//     it is re-enabled; req1 is served.
//  6. rst_n is pulsed low mid-GRANT -> grant, req_read, tx_d_valid are 0 in the same cycle;
//     after release, with both requesters eligible, req0 is granted first.

Source files
------------

// File: rtl/tx_source_arbiter.sv
// rtl/tx_source_arbiter.sv - packet-granular round-robin arbiter sharing the tx byte interface
// Bursts are capped at MAX_BURST pops and every grant is followed by GAP_CYCLES of idle.
module tx_source_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int MAX_BURST  = 64,
   parameter int GAP_CYCLES = 4
) (
   input  logic                 clk_bit,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_enable,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_read,
   output logic [7:0]           tx_d_in,
   output logic                 tx_d_valid,
   input  logic                 tx_read_enable,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 burst_trunc
);

   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_GAP} state_t;

   state_t             state, state_nxt;
   logic [OW-1:0]      owner, ptr, pick_idx;
   logic               pick_found;
   logic [CW-1:0]      burst_cnt;
   logic [7:0]         gap_cnt;
   logic [NUM_REQ-1:0] eligible;
   logic               pop, pkt_end, burst_end;

   assign eligible = req_enable & req_valid;

   // Scan downward so the lowest rotated offset from the pointer wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[(int'(ptr) + k) % NUM_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = OW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      grant      = '0;
      req_read   = '0;
      tx_d_in    = 8'h00;
      tx_d_valid = 1'b0;
      if (state == S_GRANT) begin
         grant[owner]    = 1'b1;
         tx_d_in         = req_data[8*owner +: 8];
         tx_d_valid      = req_valid[owner];
         req_read[owner] = tx_read_enable & req_valid[owner];
      end
   end

   assign pop       = |req_read;
   assign pkt_end   = pop & req_last[owner];
   // A last byte landing exactly on the burst limit is a normal packet end.
   assign burst_end = pop & ~req_last[owner] & (burst_cnt == CW'(MAX_BURST - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (|eligible) state_nxt = S_ARB;
         S_ARB:   state_nxt = pick_found ? S_GRANT : S_IDLE;
         S_GRANT: if (pkt_end || burst_end) state_nxt = (GAP_CYCLES == 0) ? S_ARB : S_GAP;
         S_GAP:   if (gap_cnt <= 8'd1) state_nxt = S_ARB;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk_bit or negedge rst_n) begin
      if (!rst_n) begin
         owner       <= '0;
         ptr         <= '0;
         burst_cnt   <= '0;
         gap_cnt     <= 8'd0;
         burst_trunc <= 1'b0;
      end else begin
         burst_trunc <= burst_end;
         if (state == S_ARB && pick_found) begin
            owner     <= pick_idx;
            ptr       <= (pick_idx == OW'(NUM_REQ - 1)) ? '0 : pick_idx + OW'(1);
            burst_cnt <= '0;
         end else if (pop && burst_cnt != CW'(MAX_BURST)) begin
            burst_cnt <= burst_cnt + CW'(1);
         end
         if (state == S_GRANT && (pkt_end || burst_end))
            gap_cnt <= 8'(GAP_CYCLES);
         else if (state == S_GAP && gap_cnt != 8'd0)
            gap_cnt <= gap_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_tx_source_arbiter.sv
// tb/tb_tx_source_arbiter.sv - directed vector table plus scripted corner sequences for tx_source_arbiter
module tb_tx_source_arbiter;
   localparam int N = 2;

   logic           clk_bit = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_enable, req_valid, req_last, req_read, grant;
   logic [8*N-1:0] req_data;
   logic [7:0]     tx_d_in;
   logic           tx_d_valid, tx_read_enable, burst_trunc;

   always #5 clk_bit = ~clk_bit;

   tx_source_arbiter #(.NUM_REQ(N), .MAX_BURST(64), .GAP_CYCLES(4)) dut (
      .clk_bit(clk_bit), .rst_n(rst_n), .req_enable(req_enable), .req_valid(req_valid),
      .req_data(req_data), .req_last(req_last), .req_read(req_read), .tx_d_in(tx_d_in),
      .tx_d_valid(tx_d_valid), .tx_read_enable(tx_read_enable), .grant(grant),
      .burst_trunc(burst_trunc));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] en, val, last;
      logic [15:0] data;
      logic       rd;
      logic [1:0] g, r;
      logic       v;
      logic [7:0] d;
   } vec_t;
   vec_t tbl[14];

   // source model
   int         rem[N], pkt[N], pos[N];
   bit         hold[N];
   logic [N-1:0] src_en;
   logic [N-1:0] prev_g;
   logic [N-1:0] starts[$];
   int         pops[$];
   int         cur_pops, n_trunc;

   function automatic logic [7:0] src_byte(input int i);
      return 8'(i * 64 + pos[i]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; pkt[i] = 0; pos[i] = 0; hold[i] = 0;
      end
      src_en = '0; prev_g = '0; cur_pops = 0; n_trunc = 0;
      starts.delete(); pops.delete();
      req_enable = '0; req_valid = '0; req_last = '0; req_data = '0; tx_read_enable = 1'b1;
      @(negedge clk_bit); rst_n = 1'b0;
      repeat (2) @(negedge clk_bit);
      rst_n = 1'b1;
   endtask

   task automatic cycle();
      @(negedge clk_bit);
      for (int i = 0; i < N; i++) begin
         req_enable[i]       = src_en[i];
         req_valid[i]        = (rem[i] > 0) && !hold[i];
         req_data[8*i +: 8]  = src_byte(i);
         req_last[i]         = (pkt[i] > 0) && (pos[i] % pkt[i] == pkt[i] - 1);
      end
      tx_read_enable = 1'b1;
      #1;
      if (burst_trunc) n_trunc++;
      if (prev_g == '0 && grant != '0) begin starts.push_back(grant); cur_pops = 0; end
      if (prev_g != '0 && grant == '0) pops.push_back(cur_pops);
      prev_g = grant;
      if (req_read != '0) begin
         check("pop_matches_grant", 32'(req_read), 32'(grant));
         for (int i = 0; i < N; i++) begin
            if (req_read[i]) begin
               check($sformatf("pop_data_req%0d_byte%0d", i, pos[i]), 32'(tx_d_in), 32'(src_byte(i)));
               pos[i]++; rem[i]--; cur_pops++;
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0, budget;
      bit found;
      rst_n = 1'b0;
      req_enable = '0; req_valid = '0; req_last = '0; req_data = '0; tx_read_enable = 1'b0;

      // Vector table: req0 alone (req1 valid but disabled), 3-byte packet with one stalled read,
      // 4 gap cycles that hold off an already-waiting packet, then the next grant.
      tbl[0]  = '{1'b0, 2'b01, 2'b11, 2'b00, 16'h55A1, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 2'b01, 2'b11, 2'b00, 16'h55A1, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 2'b01, 2'b11, 2'b00, 16'h55A1, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 2'b01, 2'b11, 2'b00, 16'h55A1, 1'b1, 2'b01, 2'b01, 1'b1, 8'hA1};
      tbl[4]  = '{1'b1, 2'b01, 2'b11, 2'b00, 16'h55A2, 1'b0, 2'b01, 2'b00, 1'b1, 8'hA2};
      tbl[5]  = '{1'b1, 2'b01, 2'b11, 2'b00, 16'h55A2, 1'b1, 2'b01, 2'b01, 1'b1, 8'hA2};
      tbl[6]  = '{1'b1, 2'b01, 2'b11, 2'b01, 16'h55A3, 1'b1, 2'b01, 2'b01, 1'b1, 8'hA3};
      for (int i = 7; i <= 11; i++)
         tbl[i] = '{1'b1, 2'b01, 2'b11, 2'b01, 16'h55B1, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};
      tbl[12] = '{1'b1, 2'b01, 2'b11, 2'b01, 16'h55B1, 1'b1, 2'b01, 2'b01, 1'b1, 8'hB1};
      tbl[13] = '{1'b1, 2'b01, 2'b00, 2'b00, 16'h0000, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk_bit);
         rst_n = tbl[i].rst; req_enable = tbl[i].en; req_valid = tbl[i].val;
         req_last = tbl[i].last; req_data = tbl[i].data; tx_read_enable = tbl[i].rd;
         #1;
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         check($sformatf("vec%0d_req_read", i), 32'(req_read), 32'(tbl[i].r));
         check($sformatf("vec%0d_tx_d_valid", i), 32'(tx_d_valid), 32'(tbl[i].v));
         check($sformatf("vec%0d_tx_d_in", i), 32'(tx_d_in), 32'(tbl[i].d));
         check($sformatf("vec%0d_burst_trunc", i), 32'(burst_trunc), 32'd0);
      end

      // Round-robin alternation with 2-byte packets on both sources
      model_reset();
      src_en = 2'b11; rem[0] = 1000; rem[1] = 1000; pkt[0] = 2; pkt[1] = 2;
      budget = 0;
      while (starts.size() < 6 && budget < 200) begin cycle(); budget++; end
      check("rr_grant_count", 32'(starts.size() >= 6), 32'd1);
      for (int k = 0; k < 6 && k < starts.size(); k++)
         check($sformatf("rr_owner%0d", k), 32'(starts[k]), (k % 2) ? 32'h2 : 32'h1);
      for (int k = 0; k < 5 && k < pops.size(); k++)
         check($sformatf("rr_pops%0d", k), 32'(pops[k]), 32'd2);

      // 70 bytes without last: 64-byte truncated burst, then 6 more in the next grant
      model_reset();
      src_en = 2'b10; rem[1] = 70;
      repeat (120) cycle();
      check("trunc_total_pops", 32'(pos[1]), 32'd70);
      check("trunc_pulses", 32'(n_trunc), 32'd1);
      check("trunc_ended_grants", 32'(pops.size()), 32'd1);
      if (pops.size() > 0) check("trunc_first_burst", 32'(pops[0]), 32'd64);
      check("trunc_grant_starts", 32'(starts.size()), 32'd2);
      check("trunc_still_granted", 32'(grant), 32'h2);
      check("trunc_second_burst", 32'(cur_pops), 32'd6);

      // Owner stalls 5 cycles mid-packet with tx reading continuously
      model_reset();
      src_en = 2'b01; rem[0] = 8; pkt[0] = 8;
      budget = 0;
      while (pos[0] < 3 && budget < 20) begin cycle(); budget++; end
      check("stall_reached_byte3", 32'(pos[0]), 32'd3);
      hold[0] = 1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check($sformatf("stall%0d_tx_d_valid", k), 32'(tx_d_valid), 32'd0);
         check($sformatf("stall%0d_req_read", k), 32'(req_read), 32'd0);
         check($sformatf("stall%0d_grant", k), 32'(grant), 32'h1);
      end
      hold[0] = 0;
      budget = 0;
      while (pops.size() == 0 && budget < 30) begin cycle(); budget++; end
      check("stall_packet_done", 32'(pops.size()), 32'd1);
      if (pops.size() > 0) check("stall_packet_len", 32'(pops[0]), 32'd8);
      check("stall_single_grant", 32'(starts.size()), 32'd1);

      // req_enable[0] drops mid-packet
      model_reset();
      src_en = 2'b11; rem[0] = 1000; rem[1] = 1000; pkt[0] = 4; pkt[1] = 4;
      budget = 0;
      while (pos[0] < 1 && budget < 20) begin cycle(); budget++; end
      src_en[0] = 1'b0;
      budget = 0;
      while (pops.size() == 0 && budget < 20) begin cycle(); budget++; end
      check("dis_packet_completed", 32'(pops.size()), 32'd1);
      if (pops.size() > 0) check("dis_packet_len", 32'(pops[0]), 32'd4);
      s0 = starts.size();
      repeat (40) cycle();
      check("dis_req1_served", 32'(starts.size() - s0 >= 2), 32'd1);
      for (int k = s0; k < starts.size(); k++)
         check($sformatf("dis_owner%0d", k), 32'(starts[k]), 32'h2);
      src_en[0] = 1'b1;
      s0 = starts.size();
      found = 0; budget = 0;
      while (!found && budget < 40) begin
         cycle(); budget++;
         for (int k = s0; k < starts.size(); k++) if (starts[k] == 2'b01) found = 1;
      end
      check("dis_req0_regranted", 32'(found), 32'd1);

      // Reset mid-grant while req0 owns the bus (pointer then favours req1)
      model_reset();
      src_en = 2'b11; rem[0] = 1000; rem[1] = 1000; pkt[0] = 4; pkt[1] = 4;
      budget = 0;
      while (pos[0] < 2 && budget < 20) begin cycle(); budget++; end
      check("rst_pre_grant", 32'(grant), 32'h1);
      @(negedge clk_bit);
      rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_req_read", 32'(req_read), 32'd0);
      check("rst_tx_d_valid", 32'(tx_d_valid), 32'd0);
      check("rst_tx_d_in", 32'(tx_d_in), 32'd0);
      @(negedge clk_bit);
      rst_n = 1'b1;
      starts.delete(); pops.delete(); prev_g = '0;
      budget = 0;
      while (starts.size() == 0 && budget < 20) begin cycle(); budget++; end
      check("rst_first_grant_seen", 32'(starts.size()), 32'd1);
      if (starts.size() > 0) check("rst_first_owner", 32'(starts[0]), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
